// File: rtl/fwd_pkg.sv
// Shared constants and types for the ID-stage forwarding/hazard unit.
package fwd_pkg;

   localparam int unsigned STG_EXE     = 0;
   localparam int unsigned STG_MEM     = 1;
   localparam int unsigned STG_WB      = 2;
   localparam int unsigned NUM_STG_DEF = 3;
   localparam int unsigned FWD_SRC_RF  = NUM_STG_DEF;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } fsm_state_e;

endpackage

// File: rtl/fwd_port_sel.sv
// One read port: priority match over downstream stages, youngest first.
// Address 0 always reads zero and reports the register file as its source.
module fwd_port_sel #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned NUM_STG = 3,
   parameter int unsigned SRC_W   = 2
) (
   input  logic                      en_i,
   input  logic [ADDR_W-1:0]         addr_i,
   input  logic [DATA_W-1:0]         rf_data_i,
   input  logic [NUM_STG-1:0]        wen_i,
   input  logic [NUM_STG*ADDR_W-1:0] waddr_i,
   input  logic [NUM_STG*DATA_W-1:0] wdata_i,
   input  logic [NUM_STG-1:0]        pend_i,
   output logic [DATA_W-1:0]         data_o,
   output logic [SRC_W-1:0]          src_o,
   output logic                      pend_o
);

   logic hit;

   always_comb begin
      data_o = rf_data_i;
      src_o  = SRC_W'(NUM_STG);
      pend_o = 1'b0;
      hit    = 1'b0;
      if (addr_i == '0) begin
         data_o = '0;
      end else begin
         // First (youngest) match wins, so an older ready copy never masks a pending one.
         for (int unsigned s = 0; s < NUM_STG; s++) begin
            if (!hit && en_i && wen_i[s] && (waddr_i[s*ADDR_W +: ADDR_W] == addr_i)) begin
               hit    = 1'b1;
               data_o = wdata_i[s*DATA_W +: DATA_W];
               src_o  = SRC_W'(s);
               pend_o = pend_i[s];
            end
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID-stage forwarding and load-use hazard unit with ID/EX operand latch,
// flush, stall-length watchdog and per-port source reporting.
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned NUM_RD    = 2,
   parameter int unsigned NUM_STG   = NUM_STG_DEF,
   parameter int unsigned MAX_STALL = 15,
   parameter int unsigned SRC_W     = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      id_valid,
   input  logic [NUM_RD-1:0]         id_rd_en,
   input  logic [NUM_RD*ADDR_W-1:0]  id_rd_addr,
   input  logic [NUM_RD*DATA_W-1:0]  id_rf_data,
   input  logic                      id_hi_rd,
   input  logic                      id_lo_rd,
   input  logic [DATA_W-1:0]         rf_hi,
   input  logic [DATA_W-1:0]         rf_lo,
   input  logic [NUM_STG-1:0]        stg_wen,
   input  logic [NUM_STG*ADDR_W-1:0] stg_waddr,
   input  logic [NUM_STG*DATA_W-1:0] stg_wdata,
   input  logic [NUM_STG-1:0]        stg_pend,
   input  logic [NUM_STG-1:0]        stg_hi_wen,
   input  logic [NUM_STG-1:0]        stg_lo_wen,
   input  logic [NUM_STG*DATA_W-1:0] stg_hi_data,
   input  logic [NUM_STG*DATA_W-1:0] stg_lo_data,
   output logic                      stall,
   output logic                      ex_valid,
   output logic [NUM_RD*DATA_W-1:0]  ex_opnd,
   output logic [DATA_W-1:0]         ex_hi,
   output logic [DATA_W-1:0]         ex_lo,
   output logic [NUM_RD*SRC_W-1:0]   ex_src,
   output logic                      err_timeout
);

   localparam int unsigned LEN_W = $clog2(MAX_STALL + 1);

   logic [NUM_RD*DATA_W-1:0] opnd_sel;
   logic [NUM_RD*SRC_W-1:0]  src_sel;
   logic [NUM_RD-1:0]        port_pend;
   logic [DATA_W-1:0]        hi_sel, lo_sel;
   logic [SRC_W-1:0]         hi_src, lo_src;
   logic                     hi_pend, lo_pend, pend_hit;
   logic                     unused_hilo;

   for (genvar p = 0; p < NUM_RD; p++) begin : g_port
      fwd_port_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_STG(NUM_STG), .SRC_W(SRC_W)) u_sel (
         .en_i      (id_rd_en[p]),
         .addr_i    (id_rd_addr[p*ADDR_W +: ADDR_W]),
         .rf_data_i (id_rf_data[p*DATA_W +: DATA_W]),
         .wen_i     (stg_wen),
         .waddr_i   (stg_waddr),
         .wdata_i   (stg_wdata),
         .pend_i    (stg_pend),
         .data_o    (opnd_sel[p*DATA_W +: DATA_W]),
         .src_o     (src_sel[p*SRC_W +: SRC_W]),
         .pend_o    (port_pend[p])
      );
   end

   // HI/LO reuse the port selector with a 1-bit address that always matches.
   fwd_port_sel #(.DATA_W(DATA_W), .ADDR_W(1), .NUM_STG(NUM_STG), .SRC_W(SRC_W)) u_hi (
      .en_i (1'b1), .addr_i (1'b1), .rf_data_i (rf_hi),
      .wen_i (stg_hi_wen), .waddr_i ({NUM_STG{1'b1}}), .wdata_i (stg_hi_data), .pend_i ('0),
      .data_o (hi_sel), .src_o (hi_src), .pend_o (hi_pend)
   );

   fwd_port_sel #(.DATA_W(DATA_W), .ADDR_W(1), .NUM_STG(NUM_STG), .SRC_W(SRC_W)) u_lo (
      .en_i (1'b1), .addr_i (1'b1), .rf_data_i (rf_lo),
      .wen_i (stg_lo_wen), .waddr_i ({NUM_STG{1'b1}}), .wdata_i (stg_lo_data), .pend_i ('0),
      .data_o (lo_sel), .src_o (lo_src), .pend_o (lo_pend)
   );

   assign unused_hilo = ^{hi_src, lo_src, id_hi_rd, id_lo_rd};

   assign pend_hit = (|port_pend) | hi_pend | lo_pend;
   assign stall    = id_valid & pend_hit & ~flush;

   fsm_state_e       state_q, state_d;
   logic [LEN_W-1:0] stall_len_q, stall_len_d;
   logic             err_q, err_d;

   always_comb begin
      state_d     = state_q;
      stall_len_d = stall_len_q;
      if (flush) begin
         state_d     = ST_RUN;
         stall_len_d = '0;
      end else begin
         unique case (state_q)
            ST_RUN: if (stall) begin
               state_d     = ST_STALL;
               stall_len_d = LEN_W'(1);
            end
            ST_STALL: if (stall) begin
               if (stall_len_q != LEN_W'(MAX_STALL)) stall_len_d = stall_len_q + LEN_W'(1);
            end else begin
               state_d     = ST_RUN;
               stall_len_d = '0;
            end
            default: begin
               state_d     = ST_RUN;
               stall_len_d = '0;
            end
         endcase
      end
      err_d = err_q | (stall_len_d == LEN_W'(MAX_STALL));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         stall_len_q <= '0;
         err_q       <= 1'b0;
         ex_valid    <= 1'b0;
         ex_opnd     <= '0;
         ex_hi       <= '0;
         ex_lo       <= '0;
         ex_src      <= {NUM_RD{SRC_W'(NUM_STG)}};
      end else begin
         state_q     <= state_d;
         stall_len_q <= stall_len_d;
         err_q       <= err_d;
         if (stall || flush) begin
            ex_valid <= 1'b0;
         end else begin
            ex_valid <= id_valid;
            ex_opnd  <= opnd_sel;
            ex_hi    <= hi_sel;
            ex_lo    <= lo_sel;
            ex_src   <= src_sel;
         end
      end
   end

   assign err_timeout = err_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit with default parameters.
module tb_fwd_hazard_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        id_valid;
   logic [1:0]  id_rd_en;
   logic [9:0]  id_rd_addr;
   logic [63:0] id_rf_data;
   logic        id_hi_rd, id_lo_rd;
   logic [31:0] rf_hi, rf_lo;
   logic [2:0]  stg_wen;
   logic [14:0] stg_waddr;
   logic [95:0] stg_wdata;
   logic [2:0]  stg_pend;
   logic [2:0]  stg_hi_wen, stg_lo_wen;
   logic [95:0] stg_hi_data, stg_lo_data;
   logic        stall, ex_valid, err_timeout;
   logic [63:0] ex_opnd;
   logic [31:0] ex_hi, ex_lo;
   logic [3:0]  ex_src;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   fwd_hazard_unit #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_STG(3), .MAX_STALL(15), .SRC_W(2)) dut (
      .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
      .id_rd_en(id_rd_en), .id_rd_addr(id_rd_addr), .id_rf_data(id_rf_data),
      .id_hi_rd(id_hi_rd), .id_lo_rd(id_lo_rd), .rf_hi(rf_hi), .rf_lo(rf_lo),
      .stg_wen(stg_wen), .stg_waddr(stg_waddr), .stg_wdata(stg_wdata), .stg_pend(stg_pend),
      .stg_hi_wen(stg_hi_wen), .stg_lo_wen(stg_lo_wen),
      .stg_hi_data(stg_hi_data), .stg_lo_data(stg_lo_data),
      .stall(stall), .ex_valid(ex_valid), .ex_opnd(ex_opnd), .ex_hi(ex_hi), .ex_lo(ex_lo),
      .ex_src(ex_src), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      flush = 0; id_valid = 0; id_rd_en = '0; id_rd_addr = '0; id_rf_data = '0;
      id_hi_rd = 0; id_lo_rd = 0; rf_hi = '0; rf_lo = '0;
      stg_wen = '0; stg_waddr = '0; stg_wdata = '0; stg_pend = '0;
      stg_hi_wen = '0; stg_lo_wen = '0; stg_hi_data = '0; stg_lo_data = '0;
   endtask

   task automatic set_stg(input int s, input logic [4:0] wa, input logic [31:0] wd, input logic pd);
      stg_wen[s]          = 1'b1;
      stg_waddr[s*5 +: 5]  = wa;
      stg_wdata[s*32 +: 32] = wd;
      stg_pend[s]         = pd;
   endtask

   task automatic rd_port(input int p, input logic [4:0] a, input logic [31:0] rfd);
      id_rd_en[p]            = 1'b1;
      id_rd_addr[p*5 +: 5]    = a;
      id_rf_data[p*32 +: 32]  = rfd;
   endtask

   initial begin
      clr();
      rst = 0;
      tick(); tick();
      check("rst_ex_valid", ex_valid, 0);
      check("rst_ex_opnd", ex_opnd, 0);
      check("rst_ex_src", ex_src, 4'hF);
      check("rst_err", err_timeout, 0);
      rst = 1;
      tick();

      // 1: two ready producers of r5, youngest wins
      clr(); id_valid = 1; rd_port(0, 5, 32'h55);
      set_stg(0, 5, 32'h11, 0); set_stg(1, 5, 32'h22, 0);
      #1 check("t1_stall", stall, 0);
      tick();
      check("t1_opnd0", ex_opnd[31:0], 32'h11);
      check("t1_src0", ex_src[1:0], 0);
      check("t1_valid", ex_valid, 1);

      // 2: load-use on r7, then forwarded from MEM
      clr(); id_valid = 1; rd_port(1, 7, 32'h66); set_stg(0, 7, 32'hDEAD, 1);
      #1 check("t2_stall", stall, 1);
      tick();
      check("t2_bubble", ex_valid, 0);
      check("t2_hold", ex_opnd[31:0], 32'h11);
      clr(); id_valid = 1; rd_port(1, 7, 32'h66); set_stg(1, 7, 32'hAB, 0);
      #1 check("t2_nostall", stall, 0);
      tick();
      check("t2_opnd1", ex_opnd[63:32], 32'hAB);
      check("t2_src1", ex_src[3:2], 1);
      check("t2_valid", ex_valid, 1);

      // pending younger must not be overridden by ready older; both ports pending
      clr(); id_valid = 1; rd_port(0, 9, 0); rd_port(1, 10, 0);
      set_stg(0, 9, 32'h1, 1); set_stg(1, 10, 32'h2, 1); set_stg(2, 9, 32'h3, 0);
      #1 check("both_pend_stall", stall, 1);
      tick();
      check("both_pend_bubble", ex_valid, 0);

      // 3: r0 always zero
      clr(); id_valid = 1; rd_port(0, 0, 32'h77); set_stg(0, 0, 32'hFFFF, 0);
      tick();
      check("t3_opnd0", ex_opnd[31:0], 0);
      check("t3_src0", ex_src[1:0], 3);

      // 4: HI/LO forwarding alongside a GPR read
      clr(); id_valid = 1; id_hi_rd = 1; rf_hi = 32'h9; rf_lo = 32'h3; rd_port(0, 4, 32'h44);
      stg_hi_wen = 3'b110; stg_hi_data = {32'h5555, 32'h1234, 32'h0};
      stg_lo_wen = 3'b011; stg_lo_data = {32'h0, 32'hBBBB, 32'hAAAA};
      tick();
      check("t4_hi_mem", ex_hi, 32'h1234);
      check("t4_lo_exe", ex_lo, 32'hAAAA);
      check("t4_gpr_rf", ex_opnd[31:0], 32'h44);
      stg_hi_wen = '0; stg_lo_wen = '0;
      tick();
      check("t4_hi_rf", ex_hi, 32'h9);
      check("t4_lo_rf", ex_lo, 32'h3);

      // 5: watchdog
      clr(); id_valid = 1; rd_port(0, 12, 0); set_stg(0, 12, 32'h5, 1);
      repeat (14) tick();
      check("t5_err_early", err_timeout, 0);
      tick();
      check("t5_err_set", err_timeout, 1);
      clr(); id_valid = 1; rd_port(0, 12, 32'h8);
      tick();
      check("t5_err_sticky", err_timeout, 1);
      check("t5_valid_after", ex_valid, 1);
      rst = 0;
      #1 check("t5_err_cleared", err_timeout, 0);
      rst = 1;
      tick();

      // 6: flush during stall, and flush restarts the stall counter
      clr(); id_valid = 1; rd_port(0, 13, 0); set_stg(0, 13, 32'h6, 1);
      repeat (10) tick();
      flush = 1;
      #1 check("t6_flush_nostall", stall, 0);
      tick();
      check("t6_flush_bubble", ex_valid, 0);
      flush = 0;
      repeat (10) tick();
      check("t6_len_restart", err_timeout, 0);

      // reset mid-stall after a real instruction was latched
      clr(); id_valid = 1; rd_port(0, 3, 32'hCAFE);
      tick();
      check("t6_latched", ex_opnd[31:0], 32'hCAFE);
      set_stg(0, 3, 32'h7, 1);
      tick();
      rst = 0;
      #1;
      check("t6_rst_valid", ex_valid, 0);
      check("t6_rst_opnd", ex_opnd, 0);
      check("t6_rst_src", ex_src, 4'hF);
      check("t6_rst_err", err_timeout, 0);
      rst = 1;
      clr();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
